// File: rtl/instruction_cache_if.sv
// instruction_cache_if: fetch-side and block-memory-side signals of the instruction cache
interface instruction_cache_if;
  logic         READ;
  logic [31:0]  PC_ADDRESS;
  logic [31:0]  INSTRUCTION;
  logic         BUSYWAIT;
  logic         MEM_READ;
  logic [27:0]  MEM_ADDRESS;
  logic [127:0] MEM_READDATA;
  logic         MEM_BUSYWAIT;
  modport slave (
    input  READ, PC_ADDRESS, MEM_READDATA, MEM_BUSYWAIT,
    output INSTRUCTION, BUSYWAIT, MEM_READ, MEM_ADDRESS
  );
  modport master (
    output READ, PC_ADDRESS, MEM_READDATA, MEM_BUSYWAIT,
    input  INSTRUCTION, BUSYWAIT, MEM_READ, MEM_ADDRESS
  );
endinterface

// File: rtl/instruction_cache.sv
// instruction_cache: direct-mapped read-only I-cache, 16-byte lines, combinational hit,
// whole-block refill over the MEM_READ/MEM_BUSYWAIT handshake on a miss
module instruction_cache #(
  parameter int INDEX_BITS = 3
) (
  input logic CLK,
  input logic RESET_N,
  instruction_cache_if.slave bus
);
  localparam int TAG_BITS = 28 - INDEX_BITS;
  localparam int LINES = 1 << INDEX_BITS;
  typedef enum logic [1:0] {IDLE, FETCH, UPDATE} state_t;
  state_t state_q, state_d;
  logic [LINES-1:0] valid_q, valid_d;
  logic [TAG_BITS-1:0] tag_q [LINES];
  logic [127:0] data_q [LINES];
  logic [127:0] block_q, block_d;
  logic [27:0] mem_address_q, mem_address_d;
  logic mem_read_q, mem_read_d;
  logic first_q, first_d;
  logic [INDEX_BITS-1:0] idx, fill_idx;
  logic [TAG_BITS-1:0] tag;
  logic [1:0] off;
  logic hit;
  logic unused_byte_offset;
  assign unused_byte_offset = ^bus.PC_ADDRESS[1:0];
  assign off = bus.PC_ADDRESS[3:2];
  assign idx = bus.PC_ADDRESS[3+INDEX_BITS:4];
  assign tag = bus.PC_ADDRESS[31:4+INDEX_BITS];
  // the refill target comes from the latched block address, not the live PC
  assign fill_idx = mem_address_q[INDEX_BITS-1:0];
  assign hit = bus.READ && valid_q[idx] && tag_q[idx] == tag;
  assign bus.INSTRUCTION = hit ? data_q[idx][{off, 5'b0} +: 32] : 32'h0;
  assign bus.BUSYWAIT = state_q != IDLE || (bus.READ && !hit);
  assign bus.MEM_READ = mem_read_q;
  assign bus.MEM_ADDRESS = mem_address_q;
  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    block_d = block_q;
    mem_address_d = mem_address_q;
    mem_read_d = mem_read_q;
    first_d = 1'b0;
    case (state_q)
      IDLE: if (bus.READ && !hit) begin
        state_d = FETCH;
        mem_address_d = bus.PC_ADDRESS[31:4];
        mem_read_d = 1'b1;
        first_d = 1'b1;
      end
      // MEM_BUSYWAIT may not have risen yet on the first FETCH edge
      FETCH: if (!first_q && !bus.MEM_BUSYWAIT) begin
        state_d = UPDATE;
        block_d = bus.MEM_READDATA;
        mem_read_d = 1'b0;
      end
      default: begin
        state_d = IDLE;
        valid_d[fill_idx] = 1'b1;
      end
    endcase
  end
  always_ff @(posedge CLK or negedge RESET_N)
    if (!RESET_N) begin
      state_q <= IDLE;
      valid_q <= '0;
      block_q <= '0;
      mem_address_q <= '0;
      mem_read_q <= 1'b0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      block_q <= block_d;
      mem_address_q <= mem_address_d;
      mem_read_q <= mem_read_d;
      first_q <= first_d;
    end
  always_ff @(posedge CLK)
    if (state_q == UPDATE) begin
      data_q[fill_idx] <= block_q;
      tag_q[fill_idx] <= mem_address_q[27:INDEX_BITS];
    end
endmodule

// File: tb/tb_instruction_cache.sv
// tb_instruction_cache: randomized fetch stream against a timeline-level cache model,
// plus directed reset/cold-miss/hit/conflict/redirect/mid-fill-reset scenarios
module tb_instruction_cache;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int vectors = 0;
  int errors = 0;
  int lat = 5;
  int mcnt = 0;
  int cyc = 0;
  instruction_cache_if bus();
  instruction_cache #(.INDEX_BITS(3)) dut (.CLK(clk), .RESET_N(rst_n), .bus(bus));
  always #5 clk = ~clk;
  function automatic logic [31:0] word_at(logic [29:0] wa);
    return (32'(wa) + 32'd1) * 32'h11111111;
  endfunction
  function automatic logic [127:0] block_at(logic [27:0] ba);
    logic [127:0] b;
    for (int k = 0; k < 4; k++) b[32*k +: 32] = word_at({ba, 2'(k)});
    return b;
  endfunction
  // memory: busy for lat cycles after MEM_READ rises, garbage data while busy
  always @(posedge clk) mcnt <= bus.MEM_READ ? mcnt + 1 : 0;
  assign bus.MEM_BUSYWAIT = bus.MEM_READ && (mcnt < lat);
  assign bus.MEM_READDATA = bus.MEM_BUSYWAIT ? {4{32'hDEADBEEF}} : block_at(bus.MEM_ADDRESS);
  bit m_valid [8];
  logic [24:0] m_tag [8];
  bit f = 0;
  int f_start = 0;
  int f_lat = 0;
  logic [27:0] f_addr = '0;
  function automatic bit m_hit(logic rd, logic [31:0] pc);
    return rd && m_valid[pc[6:4]] && m_tag[pc[6:4]] == pc[31:7];
  endfunction
  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  // model: a fill started at cycle t0 with latency L installs its line at the end of cycle t0+L+2
  initial forever begin
    @(posedge clk);
    if (!rst_n) begin
      f = 0;
      f_addr = '0;
      foreach (m_valid[i]) m_valid[i] = 0;
    end else if (f) begin
      if (cyc == f_start + f_lat + 2) begin
        m_valid[f_addr[2:0]] = 1;
        m_tag[f_addr[2:0]] = f_addr[27:3];
        f = 0;
      end
    end else if (bus.READ && !m_hit(bus.READ, bus.PC_ADDRESS)) begin
      f = 1;
      f_start = cyc;
      f_lat = lat;
      f_addr = bus.PC_ADDRESS[31:4];
    end
    cyc++;
  end
  logic eb, emr;
  logic [27:0] ea;
  logic [31:0] ei;
  initial forever begin
    @(negedge clk);
    ei = m_hit(bus.READ, bus.PC_ADDRESS) ? word_at(bus.PC_ADDRESS[31:2]) : 32'h0;
    if (!rst_n) begin
      eb = bus.READ;
      emr = 0;
      ea = '0;
      ei = 32'h0;
    end else if (f) begin
      eb = 1;
      emr = (cyc - f_start) <= f_lat + 1;
      ea = f_addr;
    end else begin
      eb = bus.READ && !m_hit(bus.READ, bus.PC_ADDRESS);
      emr = 0;
      ea = f_addr;
    end
    check("busywait", bus.BUSYWAIT, eb);
    check("mem_read", bus.MEM_READ, emr);
    check("mem_address", bus.MEM_ADDRESS, ea);
    if (!eb) check("instruction", bus.INSTRUCTION, ei);
  end
  task automatic drive(logic rd, logic [31:0] pc);
    @(posedge clk);
    #1;
    bus.READ = rd;
    bus.PC_ADDRESS = pc;
  endtask
  task automatic stall(output int n);
    n = 0;
    while (bus.BUSYWAIT && n < 64) begin
      n++;
      @(negedge clk);
    end
  endtask
  int n;
  initial begin
    bus.READ = 1'b1;
    bus.PC_ADDRESS = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_mem_read", bus.MEM_READ, 0);
    check("rst_mem_address", bus.MEM_ADDRESS, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("release_mem_read", bus.MEM_READ, 1);
    #1 rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    bus.PC_ADDRESS = 32'h4;
    @(negedge clk);
    check("cold_busy_c0", bus.BUSYWAIT, 1);
    @(negedge clk);
    check("cold_mem_read_c1", bus.MEM_READ, 1);
    check("cold_mem_addr_c1", bus.MEM_ADDRESS, 28'h0);
    stall(n);
    check("cold_stall", n + 1, 8);
    check("cold_instr", bus.INSTRUCTION, 32'h22222222);
    drive(1, 32'h0);
    @(negedge clk);
    check("hit0", bus.INSTRUCTION, 32'h11111111);
    check("hit0_busy", bus.BUSYWAIT, 0);
    drive(1, 32'h8);
    @(negedge clk);
    check("hit8", bus.INSTRUCTION, 32'h33333333);
    check("hit8_mem_read", bus.MEM_READ, 0);
    drive(1, 32'hC);
    @(negedge clk);
    check("hitC", bus.INSTRUCTION, 32'h44444444);
    drive(1, 32'h80);
    @(negedge clk);
    check("conflict_busy", bus.BUSYWAIT, 1);
    @(negedge clk);
    check("conflict_addr", bus.MEM_ADDRESS, 28'h8);
    stall(n);
    check("conflict_instr", bus.INSTRUCTION, 32'h33333331);
    drive(1, 32'h0);
    @(negedge clk);
    check("refill0_busy", bus.BUSYWAIT, 1);
    @(negedge clk);
    check("refill0_addr", bus.MEM_ADDRESS, 28'h0);
    stall(n);
    drive(1, 32'h10);
    drive(1, 32'h20);
    @(negedge clk);
    check("redirect_hold_addr", bus.MEM_ADDRESS, 28'h1);
    n = 0;
    while (!(bus.MEM_READ && bus.MEM_ADDRESS == 28'h2) && n < 64) begin
      n++;
      @(negedge clk);
    end
    check("redirect_second_fill", bus.MEM_ADDRESS, 28'h2);
    stall(n);
    check("redirect_instr20", bus.INSTRUCTION, 32'h99999999);
    drive(1, 32'h10);
    @(negedge clk);
    check("line1_busy", bus.BUSYWAIT, 0);
    check("line1_instr", bus.INSTRUCTION, 32'h55555555);
    drive(1, 32'h40);
    @(negedge clk);
    @(negedge clk);
    check("midfetch_mem_read", bus.MEM_READ, 1);
    #1 rst_n = 1'b0;
    bus.READ = 1'b0;
    #1;
    check("midreset_mem_read", bus.MEM_READ, 0);
    check("midreset_busy", bus.BUSYWAIT, 0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    bus.READ = 1'b1;
    @(negedge clk);
    stall(n);
    check("refetch_stall", n, 8);
    check("refetch_instr", bus.INSTRUCTION, 32'h22222221);
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #1;
      if (!f && $urandom_range(0, 3) == 0) lat = $urandom_range(1, 6);
      rst_n = !rst_n ? 1'b1 : ($urandom_range(0, 199) != 0);
      bus.READ = $urandom_range(0, 9) != 0;
      bus.PC_ADDRESS = $urandom_range(0, 3) == 0 ? $urandom : ($urandom & 32'h1FC);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
